// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
// PS/2 keyboard receiver. Synchronises and debounces the raw PS/2 clock and
// data lines, decodes 11-bit frames (start, 8 data bits LSB first, odd
// parity, stop) with a frame timeout, and buffers good scan codes in a
// first-word-fall-through FIFO.
//
// Ports:
//   Clock       system clock, all logic on posedge
//   Reset       asynchronous active-low reset
//   PS2_CLK     raw PS/2 clock line (asynchronous)
//   PS2_DATA    raw PS/2 data line (asynchronous)
//   iPop        consume FIFO head this cycle (ignored when empty)
//   iClearErr   clear the sticky overflow flag
//   oData       FIFO head byte, 0 while empty
//   oValid      FIFO not empty
//   oCount      FIFO occupancy, 0..FIFO_DEPTH
//   oParityErr  one-cycle pulse on a parity failure
//   oFrameErr   one-cycle pulse on a bad start/stop bit or timeout
//   oOverflow   sticky: a good byte was dropped because the FIFO was full
module ps2_rx_fifo #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned SAMPLE_DIV     = 2,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CW             = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          PS2_CLK,
    input  logic          PS2_DATA,
    input  logic          iPop,
    input  logic          iClearErr,
    output logic [7:0]    oData,
    output logic          oValid,
    output logic [CW-1:0] oCount,
    output logic          oParityErr,
    output logic          oFrameErr,
    output logic          oOverflow
);

    localparam int unsigned DIVW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchronisers, sample strobe, filters.
    // Everything resets to the idle-bus level (1).
    // ------------------------------------------------------------------
    logic [1:0]            clk_sync_q, dat_sync_q;
    logic [DIVW-1:0]       div_q;
    logic                  strobe;
    logic [FILTER_LEN-1:0] clk_sh_q, dat_sh_q;
    logic                  clk_f_q, dat_f_q, clk_f_d1_q;
    logic                  fall;

    assign strobe = (div_q == DIVW'(SAMPLE_DIV - 1));
    assign fall   = clk_f_d1_q & ~clk_f_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            div_q      <= '0;
            clk_sh_q   <= '1;
            dat_sh_q   <= '1;
            clk_f_q    <= 1'b1;
            dat_f_q    <= 1'b1;
            clk_f_d1_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DATA};
            div_q      <= strobe ? '0 : div_q + 1'b1;
            if (strobe) begin
                clk_sh_q <= {clk_sh_q[FILTER_LEN-2:0], clk_sync_q[1]};
                dat_sh_q <= {dat_sh_q[FILTER_LEN-2:0], dat_sync_q[1]};
            end
            // Level changes only on a full run of equal samples, else holds.
            if (&clk_sh_q)       clk_f_q <= 1'b1;
            else if (~|clk_sh_q) clk_f_q <= 1'b0;
            if (&dat_sh_q)       dat_f_q <= 1'b1;
            else if (~|dat_sh_q) dat_f_q <= 1'b0;
            clk_f_d1_q <= clk_f_q;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM with timeout; advances only on a filtered clock fall.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

    state_e        state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bitcnt_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    logic          perr_q, ferr_q;
    logic          push;

    // Push is decided in the stop-bit fall cycle so the byte lands in the
    // FIFO at the same edge that registers the error pulses.
    assign push = fall && (state_q == S_STOP) && dat_f_q && (^{shift_q, par_q});

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            if (fall) begin
                tmo_q <= '0;
                case (state_q)
                    S_IDLE: begin
                        if (!dat_f_q) begin
                            state_q  <= S_DATA;
                            bitcnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        shift_q  <= {dat_f_q, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == 3'd7) state_q <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_q   <= dat_f_q;
                        state_q <= S_STOP;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        // Stop error outranks parity error.
                        if (!dat_f_q)                 ferr_q <= 1'b1;
                        else if (!(^{shift_q, par_q})) perr_q <= 1'b1;
                    end
                endcase
            end else if (state_q == S_IDLE) begin
                tmo_q <= '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_q <= S_IDLE;
                ferr_q  <= 1'b1;
                tmo_q   <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-code FIFO (first-word fall-through).
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          full, pop_ok, wr_ok;

    assign full   = (cnt_q == CW'(FIFO_DEPTH));
    assign pop_ok = iPop && (cnt_q != '0);
    // A pop frees the slot, so a push into a full FIFO is still accepted.
    assign wr_ok  = push && (!full || pop_ok);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (wr_ok)  wr_d = wr_q + 1'b1;
        if (pop_ok) rd_d = rd_q + 1'b1;
        if (wr_ok && !pop_ok)      cnt_d = cnt_q + CW'(1);
        else if (!wr_ok && pop_ok) cnt_d = cnt_q - CW'(1);
        // A new overflow beats a simultaneous clear.
        if (push && !wr_ok)  ovf_d = 1'b1;
        else if (iClearErr)  ovf_d = 1'b0;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_ok) mem_q[wr_q] <= shift_q;
    end

    assign oValid     = (cnt_q != '0);
    assign oCount     = cnt_q;
    assign oData      = oValid ? mem_q[rd_q] : 8'h00;
    assign oParityErr = perr_q;
    assign oFrameErr  = ferr_q;
    assign oOverflow  = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Testbench for ps2_rx_fifo: drives PS/2 frames on the raw lines, keeps a
// queue model of the FIFO contents and error counts, and compares the DUT
// against it every cycle while no frame is in flight.
module tb_ps2_rx_fifo;

    localparam int FL     = 8;
    localparam int SD     = 2;
    localparam int DEPTH  = 8;
    localparam int TMO    = 1000;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int H      = 30;   // PS/2 half bit period in clocks
    localparam int SETTLE = 60;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          PS2_CLK = 1'b1;
    logic          PS2_DATA = 1'b1;
    logic          iPop = 1'b0;
    logic          iClearErr = 1'b0;
    logic [7:0]    oData;
    logic          oValid;
    logic [CW-1:0] oCount;
    logic          oParityErr, oFrameErr, oOverflow;

    ps2_rx_fifo #(
        .FILTER_LEN(FL),
        .SAMPLE_DIV(SD),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clock(Clock), .Reset(Reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .iPop(iPop), .iClearErr(iClearErr), .oData(oData), .oValid(oValid),
        .oCount(oCount), .oParityErr(oParityErr), .oFrameErr(oFrameErr),
        .oOverflow(oOverflow)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    // Model state
    logic [7:0] q[$];
    bit  ovf_m = 1'b0;
    bit  stable = 1'b0;
    int  exp_par = 0, exp_frm = 0, par_seen = 0, frm_seen = 0;
    logic prev_par = 1'b0, prev_frm = 1'b0;
    int  lat = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #2;
    endtask

    task automatic align();
        while (cyc % SD != 0) tick(1);
    endtask

    task automatic ps2_bit(input logic b, output int fall_cyc);
        PS2_DATA = b;
        tick(H);
        PS2_CLK = 1'b0;
        fall_cyc = cyc;
        tick(H);
        PS2_CLK = 1'b1;
    endtask

    task automatic pop_once();
        iPop = 1'b1;
        tick(1);
        iPop = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic clear_once();
        iClearErr = 1'b1;
        tick(1);
        iClearErr = 1'b0;
        ovf_m = 1'b0;
    endtask

    // mode: 0 plain, 1 pop aligned with the push, 2 clear aligned with the
    // push, 3 plain and measure raw stop-fall to oValid latency.
    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input int mode);
        logic [10:0] f;
        int k;
        stable = 1'b0;
        align();
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(f[i], k);
        PS2_DATA = f[10];
        tick(H);
        PS2_CLK = 1'b0;
        k = cyc;
        if (mode == 1 || mode == 2) begin
            tick(lat - 1);
            if (mode == 1) iPop = 1'b1; else iClearErr = 1'b1;
            tick(1);
            iPop = 1'b0;
            iClearErr = 1'b0;
            if (mode == 1) begin
                void'(q.pop_front());
                q.push_back(b);
                chk("same_cycle_count", int'(oCount), 8);
                chk("same_cycle_no_ovf", int'(oOverflow), 0);
            end else begin
                ovf_m = 1'b1;
                chk("clear_vs_ovf_count", int'(oCount), 8);
                chk("clear_vs_ovf_flag", int'(oOverflow), 1);
            end
            tick(H - lat);
        end else if (mode == 3) begin
            for (int j = 1; j <= H; j++) begin
                tick(1);
                if (lat == 0 && oValid) lat = j;
            end
            chk("latency_in_bound", int'(lat >= 2 && lat <= 2 + FL * SD + 4), 1);
            if (lat < 2 || lat > H - 2) lat = 20;
        end else begin
            tick(H);
        end
        PS2_CLK = 1'b1;
        PS2_DATA = 1'b1;
        tick(SETTLE);
        if (mode == 0 || mode == 3) begin
            if (bad_stop)                 exp_frm++;
            else if (bad_par)             exp_par++;
            else if (q.size() == DEPTH)   ovf_m = 1'b1;
            else                          q.push_back(b);
        end
        chk("perr_count", par_seen, exp_par);
        chk("ferr_count", frm_seen, exp_frm);
        stable = 1'b1;
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    // Per-cycle comparison against the model and error-pulse monitoring.
    always @(negedge Clock) begin
        if (Reset) begin
            if (stable) begin
                chk("count", int'(oCount), q.size());
                chk("valid", int'(oValid), int'(q.size() != 0));
                if (q.size() != 0) chk("data", int'(oData), int'(q[0]));
                chk("overflow", int'(oOverflow), int'(ovf_m));
                chk("perr_quiet", int'(oParityErr), 0);
                chk("ferr_quiet", int'(oFrameErr), 0);
            end
            if (oParityErr) begin
                par_seen++;
                chk("perr_width", int'(prev_par), 0);
            end
            if (oFrameErr) begin
                frm_seen++;
                chk("ferr_width", int'(prev_frm), 0);
            end
            prev_par = oParityErr;
            prev_frm = oFrameErr;
        end else begin
            prev_par = 1'b0;
            prev_frm = 1'b0;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        int k, got, d;
        logic [7:0] pb;

        // Reset state
        tick(5);
        chk("rst_valid", int'(oValid), 0);
        chk("rst_count", int'(oCount), 0);
        chk("rst_data", int'(oData), 0);
        chk("rst_perr", int'(oParityErr), 0);
        chk("rst_ferr", int'(oFrameErr), 0);
        chk("rst_ovf", int'(oOverflow), 0);
        Reset = 1'b1;
        tick(SETTLE);
        stable = 1'b1;

        // Good frame 0x1C, with latency measurement
        send_frame(8'h1C, 1'b0, 1'b0, 3);
        chk("first_valid", int'(oValid), 1);
        chk("first_data", int'(oData), 8'h1C);
        chk("first_count", int'(oCount), 1);
        pop_once();
        chk("after_pop_count", int'(oCount), 0);
        chk("after_pop_valid", int'(oValid), 0);

        // Parity error, then stop error
        send_frame(8'h1C, 1'b1, 1'b0, 0);
        chk("parity_err_count", int'(oCount), 0);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        chk("stop_err_no_parity", par_seen, 1);

        // Short low glitch on PS2_CLK with data held low; must not start a frame
        PS2_DATA = 1'b0;
        tick(FL * SD + 10);
        PS2_CLK = 1'b0;
        tick(3 * SD);
        PS2_CLK = 1'b1;
        tick(FL * SD + 10);
        PS2_DATA = 1'b1;
        tick(FL * SD + 10);
        send_frame(8'hF0, 1'b0, 1'b0, 0);
        chk("glitch_then_f0", int'(oData), 8'hF0);
        pop_once();

        // Nine frames into an 8-deep FIFO
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 0);
        chk("full_count", int'(oCount), 8);
        chk("full_ovf", int'(oOverflow), 1);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", int'(oData), i);
            pop_once();
        end
        chk("drained_count", int'(oCount), 0);
        clear_once();
        chk("ovf_cleared", int'(oOverflow), 0);
        pop_once();
        chk("empty_pop_count", int'(oCount), 0);

        // Full FIFO: push with simultaneous pop, then push with simultaneous clear
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 0);
        send_frame(8'h18, 1'b0, 1'b0, 1);
        chk("wrapped_head", int'(oData), 8'h11);
        send_frame(8'h19, 1'b0, 1'b0, 2);
        clear_once();
        repeat (8) pop_once();
        chk("drained2_count", int'(oCount), 0);

        // Timeout after 5 data bits
        stable = 1'b0;
        align();
        pb = 8'h33;
        ps2_bit(1'b0, k);
        for (int i = 0; i < 5; i++) ps2_bit(pb[i], k);
        PS2_DATA = 1'b1;
        got = 0;
        d = 0;
        for (int j = 0; j < TMO + 100 && got == 0; j++) begin
            tick(1);
            if (oFrameErr) begin
                got = 1;
                d = cyc - k;
            end
        end
        chk("timeout_seen", got, 1);
        n_checks++;
        if (d < lat + TMO - 1 || d > lat + TMO + 1) begin
            n_fail++;
            $display("FAIL timeout_delay: got %0d cycles after raw fall, expected %0d..%0d",
                     d, lat + TMO - 1, lat + TMO + 1);
        end
        exp_frm++;
        tick(SETTLE);
        chk("timeout_ferr_count", frm_seen, exp_frm);
        chk("timeout_count", int'(oCount), 0);
        stable = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 0);
        chk("after_timeout_5a", int'(oData), 8'h5A);
        pop_once();

        // Reset mid-frame with 3 bytes buffered
        send_frame(8'h21, 1'b0, 1'b0, 0);
        send_frame(8'h22, 1'b0, 1'b0, 0);
        send_frame(8'h23, 1'b0, 1'b0, 0);
        chk("buffered_count", int'(oCount), 3);
        stable = 1'b0;
        align();
        pb = 8'hAA;
        ps2_bit(1'b0, k);
        for (int i = 0; i < 4; i++) ps2_bit(pb[i], k);
        PS2_DATA = pb[4];
        tick(H);
        PS2_CLK = 1'b0;
        tick(H / 2);
        Reset = 1'b0;
        #1;
        chk("midrst_valid", int'(oValid), 0);
        chk("midrst_count", int'(oCount), 0);
        chk("midrst_data", int'(oData), 0);
        chk("midrst_perr", int'(oParityErr), 0);
        chk("midrst_ferr", int'(oFrameErr), 0);
        chk("midrst_ovf", int'(oOverflow), 0);
        q.delete();
        ovf_m = 1'b0;
        PS2_CLK = 1'b1;
        PS2_DATA = 1'b1;
        tick(10);
        Reset = 1'b1;
        tick(SETTLE);
        chk("post_rst_count", int'(oCount), 0);
        stable = 1'b1;
        send_frame(8'h29, 1'b0, 1'b0, 0);
        chk("post_rst_29", int'(oData), 8'h29);
        chk("post_rst_29_count", int'(oCount), 1);
        pop_once();
        tick(5);

        summary();
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver. It replaces the ad-hoc clock/data filter and serial-to-parallel path with one self-contained block. The block synchronises and debounces PS2_CLK and PS2_DATA, then decodes 11-bit frames with start, parity and stop checks and a frame timeout. Valid scan codes are buffered in a first-word-fall-through FIFO that the CPU datapath drains with a pop strobe.

## Interface
- FILTER_LEN, default 8: number of consecutive equal samples required to change a filtered line level (≥2).
- SAMPLE_DIV, default 2: filter sampling period in Clock cycles (≥1).
- FIFO_DEPTH, default 8: scan-code FIFO depth; power of two, ≥2.
- TIMEOUT_CYCLES, default 50000: Clock cycles without a filtered PS2_CLK falling edge before a partial frame is aborted.
- CW, default $clog2(FIFO_DEPTH)+1: occupancy count width (derived).

- Clock  input  1  system clock, all logic on posedge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- PS2_CLK  input  1  raw PS/2 clock line, asynchronous to Clock.
- PS2_DATA  input  1  raw PS/2 data line, asynchronous to Clock.
- iPop  input  1  consume FIFO head this cycle.
- iClearErr  input  1  clears sticky oOverflow.
- oData  output  8  FIFO head byte; valid only while oValid=1.
- oValid  output  1  FIFO not empty.
- oCount  output  CW  FIFO occupancy, 0..FIFO_DEPTH.
- oParityErr  output  1  one-cycle pulse on a parity failure.
- oFrameErr  output  1  one-cycle pulse on a bad start/stop bit or a timeout.
- oOverflow  output  1  sticky; a valid byte was dropped because the FIFO was full.

## Operation
- Input conditioning:
  - 2-FF synchroniser on each PS/2 line.
  - A sample strobe fires every SAMPLE_DIV cycles and shifts the synchronised level into a FILTER_LEN shift register.
  - Filtered level goes to 1 when all bits are 1, goes to 0 when all bits are 0, and otherwise holds.
  - The filter shift registers and filtered levels reset to all 1 (idle bus).
- Edge detect: a registered copy of filtered PS2_CLK; a falling edge is a one-cycle event `fall`.
- Frame FSM, advancing only on `fall` and sampling filtered data:
  - IDLE: data=0 → DATA with bit count 0. data=1 → stay in IDLE, no error (spurious edge).
  - DATA: shift LSB first; after 8 bits → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: always returns to IDLE.
    - data=1 and ^{byte,parity}=1 (odd parity): push the byte.
    - data=1 and parity wrong: pulse oParityErr, discard the byte.
    - data=0: pulse oFrameErr, discard the byte. Stop error takes priority over parity error.
- Timeout:
  - The counter clears on every `fall` and in IDLE.
  - In any non-IDLE state, reaching TIMEOUT_CYCLES → IDLE, pulse oFrameErr, discard the partial byte.
- FIFO:
  - Circular buffer; write pointer, read pointer and count.
  - oData = mem[rd_ptr], combinational from registered state.
  - Push while full: byte dropped, oOverflow set; it stays set until iClearErr=1.
  - iClearErr and a new overflow in the same cycle: overflow wins, flag stays 1.
  - iPop while empty: ignored.
  - Push and pop in the same cycle, including when full: both take effect, count unchanged, no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (async assert, sync release): FSM → IDLE, pointers and count 0, oValid=0, oData=0, oCount=0, all error outputs 0, timeout counter 0. Reset asserted mid-frame discards the frame.

## Timing
- Raw line change to filtered change: 2 sync cycles + FILTER_LEN strobes (≤ 2 + FILTER_LEN·SAMPLE_DIV cycles).
- Filtered PS2_CLK fall to FSM action: 1 cycle (edge register).
- Stop-bit `fall` cycle: FIFO written. oValid and oCount update on the next posedge. Error pulses are registered, high for exactly one cycle, aligned with where oValid would have risen.
- iPop sampled at posedge: count decrements and oData shows the next entry in the following cycle.
- A single `fall` produces one FSM step only; a glitch shorter than FILTER_LEN strobes produces no `fall`.

## Test plan
- Frame 0x1C (start 0, bits LSB first, parity 0, stop 1) at a 10 kHz PS/2 rate → oValid=1, oData=0x1C, oCount=1. Pulse iPop → oCount=0, oValid=0.
- Frame 0x1C with parity 1 → one-cycle oParityErr, oCount stays 0. Frame with stop=0 → oFrameErr, no parity pulse.
- 3-strobe low glitch on PS2_CLK mid-idle (FILTER_LEN=8) → no FSM advance. The following valid 0xF0 frame is received correctly.
- Nine frames 0x01..0x09 with FIFO_DEPTH=8 → oCount=8, oOverflow=1, pops return 0x01..0x08. iClearErr → oOverflow=0. With the FIFO full, pop and push in the same cycle → count stays 8, no overflow.
- Stop PS/2 clocking after 5 data bits → oFrameErr exactly TIMEOUT_CYCLES(+1) cycles after the last `fall`. The next frame 0x5A is received correctly.
- Reset low during bit 4 of a frame and with 3 bytes buffered → all outputs 0 immediately. After release, the FIFO is empty and a fresh 0x29 frame is received.
